// File: rtl/issue_scheduler.sv
// issue_scheduler
//   Clocked front-end for the asynchronous issuer. Two requesters are arbitrated
//   round-robin. The winning instruction word is presented to the issuer on a
//   two-phase interface: iss_data and iss_valid (issuer readyIn) are set up first,
//   then iss_trigger (issuer triggerIn) toggles once. Conditional instructions are
//   held back while flag-setting instructions are still in flight, so the
//   condition is never evaluated against stale CPSR flags.
//
//   Handshake: reqN_valid is a level. When the scheduler takes the word it raises
//   reqN_ready for exactly one cycle, which means "req_data was captured". The
//   requester must then drop valid or present its next word. Only one issue is in
//   flight at a time.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   req0_valid/data/ready       requester 0 (ready is a 1-cycle accept pulse)
//   req1_valid/data/ready       requester 1 (ready is a 1-cycle accept pulse)
//   cpsr                        flags N=31 Z=30 C=29 V=28
//   flag_wb                     1-cycle pulse: one flag-setter has written CPSR
//   iss_rdy_in                  issuer readyOut (asynchronous, synchronised here)
//   iss_data, iss_valid         issuer dataIn, readyIn
//   iss_trigger                 issuer triggerIn; toggles once per issue
//   grant_id                    requester of the current/last issue
//   retire, squash, timeout_err 1-cycle completion pulses
module issue_scheduler #(
  parameter int SYNC_STAGES = 2,
  parameter int SETUP_CYC   = 2,
  parameter int MAX_FLAGS   = 3,
  parameter int TIMEOUT     = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic [31:0] req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [31:0] req1_data,
  output logic        req1_ready,
  input  logic [31:0] cpsr,
  input  logic        flag_wb,
  input  logic        iss_rdy_in,
  output logic [31:0] iss_data,
  output logic        iss_valid,
  output logic        iss_trigger,
  output logic        grant_id,
  output logic        retire,
  output logic        squash,
  output logic        timeout_err
);

  localparam int CW = $clog2(MAX_FLAGS + 1);
  localparam int SW = (SETUP_CYC > 1) ? $clog2(SETUP_CYC) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_FIRE    = 3'd2,
    S_WAIT_LO = 3'd3,
    S_WAIT_HI = 3'd4
  } state_t;

  state_t               state;
  logic                 rr;          // preferred requester when both are eligible
  logic                 cur_setter;  // the issue in flight sets flags
  logic                 cond_ok;     // condition result sampled at FIRE
  logic [SW-1:0]        setup_cnt;
  logic [TW-1:0]        wait_cnt;
  logic [CW-1:0]        flag_cnt;
  logic [SYNC_STAGES-1:0] rdy_sync;
  logic                 rdy_s;

  // Only the flag nibble of cpsr is meaningful here.
  logic unused_cpsr_bits;
  assign unused_cpsr_bits = ^cpsr[27:0];

  function automatic logic is_setter(input logic [31:0] w);
    return (w[27:26] == 2'b00) && w[20];
  endfunction

  function automatic logic is_cond(input logic [31:0] w);
    return w[31:28] != 4'b1110;
  endfunction

  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v;
    {n, z, c, v} = f;
    case (cond)
      4'b0000: return z;                 // EQ
      4'b0001: return !z;                // NE
      4'b0010: return c;                 // CS
      4'b0011: return !c;                // CC
      4'b0100: return n;                 // MI
      4'b0101: return !n;                // PL
      4'b0110: return v;                 // VS
      4'b0111: return !v;                // VC
      4'b1000: return c && !z;           // HI
      4'b1001: return !c || z;           // LS
      4'b1010: return n == v;            // GE
      4'b1011: return n != v;            // LT
      4'b1100: return !z && (n == v);    // GT
      4'b1101: return z || (n != v);     // LE
      4'b1110: return 1'b1;              // AL
      default: return 1'b0;              // NV
    endcase
  endfunction

  // Synchroniser resets to the issuer's idle level (ready high) so a grant
  // right after reset cannot mistake an unfilled pipeline for "accepted".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_sync <= {SYNC_STAGES{1'b1}};
    end else begin
      rdy_sync <= {rdy_sync[SYNC_STAGES-2:0], iss_rdy_in};
    end
  end
  assign rdy_s = rdy_sync[SYNC_STAGES-1];

  // Arbitration
  logic blocked0, blocked1, elig0, elig1, gnt_any, gnt_sel;
  logic [31:0] gnt_word;

  always_comb begin
    blocked0 = (is_cond(req0_data) && (flag_cnt != '0)) ||
               (is_setter(req0_data) && (flag_cnt == CW'(MAX_FLAGS)));
    blocked1 = (is_cond(req1_data) && (flag_cnt != '0)) ||
               (is_setter(req1_data) && (flag_cnt == CW'(MAX_FLAGS)));
    elig0    = req0_valid && !blocked0;
    elig1    = req1_valid && !blocked1;
    gnt_any  = elig0 || elig1;
    gnt_sel  = (elig0 && elig1) ? rr : elig1;
    gnt_word = gnt_sel ? req1_data : req0_data;
  end

  // Handshake wait outcomes
  logic lo_done, hi_done, to_hit;

  always_comb begin
    lo_done = (state == S_WAIT_LO) && !rdy_s;
    hi_done = (state == S_WAIT_HI) && rdy_s;
    to_hit  = ((state == S_WAIT_LO) || (state == S_WAIT_HI)) &&
              !lo_done && !hi_done && (wait_cnt == TW'(TIMEOUT - 1));
  end

  // Outstanding flag-setter counter. A timed-out setter will never be
  // acknowledged by flag_wb, so its slot is released here. flag_wb with an
  // empty counter has nothing to acknowledge and is dropped.
  logic          cnt_inc, wb_eff, force_dec;
  logic [CW+1:0] cnt_sum, cnt_dec, cnt_nxt;

  always_comb begin
    cnt_inc   = (state == S_FIRE) && cur_setter;
    wb_eff    = flag_wb && (flag_cnt != '0);
    force_dec = to_hit && cur_setter;
    cnt_sum   = {2'b00, flag_cnt} + (CW+2)'(cnt_inc);
    cnt_dec   = (CW+2)'(wb_eff) + (CW+2)'(force_dec);
    cnt_nxt   = (cnt_sum > cnt_dec) ? (cnt_sum - cnt_dec) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_cnt <= '0;
    end else begin
      flag_cnt <= cnt_nxt[CW-1:0];
    end
  end

  // Main FSM; all interface outputs are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      rr          <= 1'b0;
      cur_setter  <= 1'b0;
      cond_ok     <= 1'b0;
      setup_cnt   <= '0;
      wait_cnt    <= '0;
      req0_ready  <= 1'b0;
      req1_ready  <= 1'b0;
      iss_data    <= '0;
      iss_valid   <= 1'b0;
      iss_trigger <= 1'b0;
      grant_id    <= 1'b0;
      retire      <= 1'b0;
      squash      <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      req0_ready  <= 1'b0;
      req1_ready  <= 1'b0;
      retire      <= 1'b0;
      squash      <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (gnt_any) begin
            iss_data   <= gnt_word;
            iss_valid  <= 1'b1;
            req0_ready <= !gnt_sel;
            req1_ready <= gnt_sel;
            grant_id   <= gnt_sel;
            rr         <= !gnt_sel;
            cur_setter <= is_setter(gnt_word);
            setup_cnt  <= '0;
            state      <= S_LOAD;
          end
        end
        S_LOAD: begin
          // iss_data/iss_valid were set at grant and stay frozen until the
          // issuer accepts, covering the setup window before the toggle.
          if (setup_cnt == SW'(SETUP_CYC - 1)) begin
            state <= S_FIRE;
          end else begin
            setup_cnt <= setup_cnt + 1'b1;
          end
        end
        S_FIRE: begin
          iss_trigger <= !iss_trigger;
          cond_ok     <= cond_pass(iss_data[31:28], cpsr[31:28]);
          wait_cnt    <= '0;
          state       <= S_WAIT_LO;
        end
        S_WAIT_LO: begin
          if (lo_done) begin
            iss_valid <= 1'b0;
            wait_cnt  <= '0;
            if (cond_ok) begin
              state <= S_WAIT_HI;
            end else begin
              squash <= 1'b1;
              state  <= S_IDLE;
            end
          end else if (to_hit) begin
            timeout_err <= 1'b1;
            iss_valid   <= 1'b0;
            state       <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_WAIT_HI: begin
          if (hi_done) begin
            retire <= 1'b1;
            state  <= S_IDLE;
          end else if (to_hit) begin
            timeout_err <= 1'b1;
            iss_valid   <= 1'b0;
            state       <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_issue_scheduler.sv
// Bench for issue_scheduler: table of single-issue transactions with
// hand-computed grant/outcome, then hand-written multi-cycle sequences
// (flag-setter hazards, counter saturation, timeout, reset mid-issue).
module tb_issue_scheduler;

  localparam int SETUP_CYC = 2;
  localparam int TIMEOUT   = 64;

  localparam logic [31:0] ADDS  = 32'hE090_0001;
  localparam logic [31:0] Z_SET = 32'h4000_0000;

  localparam int END_RET = 0;
  localparam int END_SQ  = 1;
  localparam int END_TO  = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic [31:0] req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic [31:0] cpsr;
  logic        flag_wb;
  logic        iss_rdy_in;
  logic [31:0] iss_data;
  logic        iss_valid, iss_trigger, grant_id, retire, squash, timeout_err;

  int total = 0;
  int bad   = 0;
  int n_ret = 0;
  int n_sq  = 0;
  int n_to  = 0;
  logic exp_trig;
  logic long_hold;

  typedef struct packed {
    logic        r0v;
    logic [31:0] r0d;
    logic        r1v;
    logic [31:0] r1d;
    logic [31:0] cpsr;
    logic        long_hold;
    logic        exp_gnt;
    logic [1:0]  exp_end;
  } vec_t;

  vec_t vecs[14];

  issue_scheduler #(
    .SYNC_STAGES(2), .SETUP_CYC(SETUP_CYC), .MAX_FLAGS(3), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .cpsr(cpsr), .flag_wb(flag_wb), .iss_rdy_in(iss_rdy_in),
    .iss_data(iss_data), .iss_valid(iss_valid), .iss_trigger(iss_trigger),
    .grant_id(grant_id), .retire(retire), .squash(squash), .timeout_err(timeout_err)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- issuer model ----------------
  // Idle ready high; after a trigger toggle it drops ready (accept) and then
  // raises it again (done). long_hold keeps ready low far beyond TIMEOUT.
  initial begin
    iss_rdy_in = 1'b1;
    forever begin
      @(iss_trigger);
      if (rst_n) begin
        repeat (2) @(posedge clk);
        #2 iss_rdy_in = 1'b0;
        repeat (long_hold ? 150 : 3) @(posedge clk);
        #2 iss_rdy_in = 1'b1;
      end
    end
  end

  // ---------------- pulse counters ----------------
  always @(negedge clk) begin
    if (retire === 1'b1)      n_ret++;
    if (squash === 1'b1)      n_sq++;
    if (timeout_err === 1'b1) n_to++;
  end

  // ---------------- driver / check tasks ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r0v, input logic [31:0] r0d,
                              input logic r1v, input logic [31:0] r1d,
                              input logic [31:0] c, input logic lh,
                              input logic g, input int e);
    vec_t v;
    v.r0v = r0v; v.r0d = r0d; v.r1v = r1v; v.r1d = r1d;
    v.cpsr = c; v.long_hold = lh; v.exp_gnt = g; v.exp_end = 2'(e);
    return v;
  endfunction

  task automatic pulse_flag_wb();
    @(negedge clk);
    flag_wb = 1'b1;
    @(negedge clk);
    flag_wb = 1'b0;
  endtask

  task automatic check_no_grant(input string name, input int cycles);
    int seen = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (req0_ready || req1_ready) seen++;
    end
    check(name, seen, 0);
  endtask

  task automatic wait_rdy_high();
    int n = 0;
    while (iss_rdy_in !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic run_issue(input vec_t v);
    int n, drop_n, r0, s0, t0;
    logic [31:0] d;
    logic ok;
    r0 = n_ret; s0 = n_sq; t0 = n_to;
    long_hold  = v.long_hold;
    cpsr       = v.cpsr;
    req0_valid = v.r0v; req0_data = v.r0d;
    req1_valid = v.r1v; req1_data = v.r1d;
    n = 0;
    @(negedge clk);
    while (!(req0_ready || req1_ready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!(req0_ready || req1_ready)) begin
      total++; bad++;
      $display("FAIL grant_wait: got no ready within 20 cycles expected req%0d", v.exp_gnt);
      req0_valid = 1'b0; req1_valid = 1'b0;
      return;
    end
    d = v.exp_gnt ? v.r1d : v.r0d;
    check("ready_onehot", {req1_ready, req0_ready}, v.exp_gnt ? 2'b10 : 2'b01);
    check("grant_id", grant_id, v.exp_gnt);
    check("iss_data", iss_data, d);
    check("iss_valid_set", iss_valid, 1'b1);
    check("trigger_pre", iss_trigger, exp_trig);
    req0_valid = 1'b0; req1_valid = 1'b0;
    // Trigger must toggle exactly SETUP_CYC+1 cycles after the grant edge,
    // with data/valid stable meanwhile.
    ok = 1'b1;
    for (int k = 0; k < SETUP_CYC; k++) begin
      @(negedge clk);
      if (iss_trigger !== exp_trig || iss_data !== d || iss_valid !== 1'b1) ok = 1'b0;
    end
    check("setup_stable", ok, 1'b1);
    @(negedge clk);
    exp_trig = ~exp_trig;
    check("trigger_toggle", iss_trigger, exp_trig);
    n = 0; drop_n = -1;
    while (!(retire || squash || timeout_err) && n < 200) begin
      @(negedge clk);
      n++;
      if (!iss_valid && drop_n < 0) drop_n = n;
    end
    if (v.exp_end == 2'(END_TO)) check("timeout_cycles", n - drop_n, TIMEOUT);
    repeat (4) @(negedge clk);
    #1;
    check("retire_cnt",  n_ret - r0, (v.exp_end == 2'(END_RET)) ? 1 : 0);
    check("squash_cnt",  n_sq - s0,  (v.exp_end == 2'(END_SQ))  ? 1 : 0);
    check("timeout_cnt", n_to - t0,  (v.exp_end == 2'(END_TO))  ? 1 : 0);
    check("iss_valid_clr", iss_valid, 1'b0);
    if (v.long_hold) wait_rdy_high();
  endtask

  // ---------------- test ----------------
  initial begin
    int n, r0, t0;

    // grant order tracks the round-robin pointer from reset (req0 first)
    vecs[0]  = mk(1, 32'hE080_0001, 1, 32'hE080_0002, 32'h0,        0, 0, END_RET);
    vecs[1]  = mk(1, 32'hE080_0003, 1, 32'hE080_0004, 32'h0,        0, 1, END_RET);
    vecs[2]  = mk(0, 32'h0,         1, 32'hE080_0005, 32'h0,        0, 1, END_RET);
    vecs[3]  = mk(1, 32'hE080_0006, 1, 32'hE080_0007, 32'h0,        0, 0, END_RET);
    vecs[4]  = mk(1, 32'h13A0_0001, 0, 32'h0,         Z_SET,        1, 0, END_SQ);  // NE, Z=1
    vecs[5]  = mk(0, 32'h0,         1, 32'h03A0_0002, Z_SET,        0, 1, END_RET); // EQ, Z=1
    vecs[6]  = mk(1, 32'hC3A0_0003, 0, 32'h0,         32'h9000_0000, 0, 0, END_RET); // GT N=V
    vecs[7]  = mk(0, 32'h0,         1, 32'hB3A0_0004, 32'h9000_0000, 1, 1, END_SQ);  // LT N=V
    vecs[8]  = mk(1, 32'h83A0_0005, 0, 32'h0,         32'h2000_0000, 0, 0, END_RET); // HI C
    vecs[9]  = mk(0, 32'h0,         1, 32'h93A0_0006, 32'h2000_0000, 1, 1, END_SQ);  // LS C
    vecs[10] = mk(1, 32'hF3A0_0007, 0, 32'h0,         32'hF000_0000, 1, 0, END_SQ);  // NV
    vecs[11] = mk(1, 32'hE080_0008, 0, 32'h0,         32'h0,        1, 0, END_TO);  // ready stuck low
    vecs[12] = mk(1, 32'hE080_0009, 1, 32'hE080_000A, 32'h0,        0, 1, END_RET);
    vecs[13] = mk(0, 32'h0,         1, 32'h43A0_000B, 32'h8000_0000, 0, 1, END_RET); // MI N

    // clock/reset
    rst_n = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    req0_data = '0; req1_data = '0; cpsr = '0; flag_wb = 1'b0;
    long_hold = 1'b0; exp_trig = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {req0_ready, req1_ready, iss_data, iss_valid, iss_trigger, grant_id, retire, squash, timeout_err},
          64'h0);
    rst_n = 1'b1;
    check_no_grant("idle_quiet", 5);

    // table
    for (int i = 0; i < 14; i++) run_issue(vecs[i]);

    // flag-setter then dependent EQ: held until flag_wb
    run_issue(mk(1, ADDS, 0, 32'h0, 32'h0, 0, 0, END_RET));
    cpsr = Z_SET; req0_valid = 1'b1; req0_data = 32'h03A0_0001;
    check_no_grant("eq_held", 20);
    pulse_flag_wb();
    run_issue(mk(1, 32'h03A0_0001, 0, 32'h0, Z_SET, 0, 0, END_RET));

    // blocked head on req0 (preferred) must not block req1
    run_issue(mk(0, 32'h0, 1, ADDS, 32'h0, 0, 1, END_RET));
    run_issue(mk(1, 32'h03A0_0001, 1, 32'hE080_000C, Z_SET, 0, 1, END_RET));
    req0_valid = 1'b1; req0_data = 32'h03A0_0001;
    check_no_grant("req0_still_held", 15);
    pulse_flag_wb();
    run_issue(mk(1, 32'h03A0_0001, 0, 32'h0, Z_SET, 0, 0, END_RET));

    // counter saturates at MAX_FLAGS outstanding setters
    run_issue(mk(0, 32'h0, 1, ADDS, 32'h0, 0, 1, END_RET));
    run_issue(mk(1, ADDS, 0, 32'h0, 32'h0, 0, 0, END_RET));
    run_issue(mk(0, 32'h0, 1, ADDS, 32'h0, 0, 1, END_RET));
    req0_valid = 1'b1; req0_data = ADDS;
    check_no_grant("setter_at_max", 20);
    pulse_flag_wb();
    run_issue(mk(1, ADDS, 0, 32'h0, 32'h0, 0, 0, END_RET));
    repeat (3) pulse_flag_wb();
    run_issue(mk(0, 32'h0, 1, 32'h03A0_0002, Z_SET, 0, 1, END_RET));

    // flag_wb with empty counter must not underflow (would block the setter)
    pulse_flag_wb();
    run_issue(mk(1, ADDS, 0, 32'h0, 32'h0, 0, 0, END_RET));
    pulse_flag_wb();

    // reset during WAIT_HI
    long_hold = 1'b1; cpsr = '0;
    req0_valid = 1'b1; req0_data = 32'hE080_000D;
    n = 0;
    @(negedge clk);
    while (!req0_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rst_case_grant", req0_ready, 1'b1);
    req0_valid = 1'b0;
    n = 0;
    while (iss_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("rst_case_accepted", iss_valid, 1'b0);
    repeat (5) @(negedge clk);
    r0 = n_ret; t0 = n_to;
    #1 rst_n = 1'b0;
    #1;
    check("reset_mid_outputs",
          {req0_ready, req1_ready, iss_data, iss_valid, iss_trigger, grant_id, retire, squash, timeout_err},
          64'h0);
    exp_trig = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_rdy_high();
    repeat (20) @(negedge clk);
    #1;
    check("no_retire_after_rst", n_ret - r0, 0);
    check("no_timeout_after_rst", n_to - t0, 0);
    // round-robin pointer back to req0
    run_issue(mk(1, 32'hE080_000E, 1, 32'hE080_000F, 32'h0, 0, 0, END_RET));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
